// File: rtl/m3_deadtime_gate_if.sv
// Command and gate-pin bundle for the 3-phase dead-time gate stage.
// The master side issues drive commands and observes the gates; the slave side is the gate stage itself.
interface m3_deadtime_gate_if;
  logic [2:0] phEn;
  logic [2:0] phHi;
  logic       m3forceStop;
  logic       stopClr;
  logic       aHP;
  logic       bHP;
  logic       cHP;
  logic       aLN;
  logic       bLN;
  logic       cLN;
  logic       stopped;
  logic [2:0] dtBusy;

  modport master (
    output phEn, phHi, m3forceStop, stopClr,
    input  aHP, bHP, cHP, aLN, bLN, cLN, stopped, dtBusy
  );

  modport slave (
    input  phEn, phHi, m3forceStop, stopClr,
    output aHP, bHP, cHP, aLN, bLN, cLN, stopped, dtBusy
  );
endinterface

// File: rtl/m3_deadtime_gate.sv
// Three-phase gate output stage with per-phase dead time and a latched emergency stop.
// Optional command stability filter on phEn/phHi is enabled by defining M3_DT_GLITCH_FILTER_EN.
module m3_deadtime_gate #(
  parameter int unsigned DEAD_CYC   = 50,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned GLITCH_CYC = 4
) (
  input  logic               clk50mhz,
  input  logic               nReset,
  m3_deadtime_gate_if.slave  bus
);

  // An illegal parameter set keeps every phase parked in the safe state.
  localparam logic CFG_OK = (DEAD_CYC >= 32'd1) && (DEAD_CYC <= 32'd1023) && (GLITCH_CYC >= 32'd1) &&
                            ((longint'(DEAD_CYC) - 64'sd1) < (64'sd1 <<< CNT_W));
  localparam logic [CNT_W-1:0] DT_LOAD = CNT_W'(DEAD_CYC - 32'd1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DEAD = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } state_e;

  logic [2:0]       en_s;
  logic [2:0]       hi_s;
  logic [2:0]       go_s;
  logic             stopped_q;
  logic             stopped_d;
  state_e           state_q [3];
  state_e           state_d [3];
  logic [CNT_W-1:0] cnt_q   [3];
  logic [CNT_W-1:0] cnt_d   [3];
  logic [2:0]       hp_q;
  logic [2:0]       hp_d;
  logic [2:0]       ln_q;
  logic [2:0]       ln_d;
  logic [2:0]       busy_q;
  logic [2:0]       busy_d;

`ifdef M3_DT_GLITCH_FILTER_EN
  localparam int unsigned RUN_W = $clog2(GLITCH_CYC + 32'd1);

  logic [5:0]       raw_s;
  logic [5:0]       prev_q;
  logic [5:0]       filt_q;
  logic [5:0]       filt_d;
  logic [RUN_W-1:0] run_q [6];
  logic [RUN_W-1:0] run_d [6];

  assign raw_s = {bus.phHi, bus.phEn};

  // run counts consecutive edges the raw bit has held its value, including this one.
  always_comb begin
    filt_d = filt_q;
    run_d  = run_q;
    for (int j = 0; j < 6; j++) begin
      if (raw_s[j] != prev_q[j]) begin
        run_d[j] = RUN_W'(1);
      end else if (run_q[j] < RUN_W'(GLITCH_CYC)) begin
        run_d[j] = run_q[j] + RUN_W'(1);
      end else begin
        run_d[j] = run_q[j];
      end
      if (run_d[j] >= RUN_W'(GLITCH_CYC)) begin
        filt_d[j] = raw_s[j];
      end else begin
        filt_d[j] = filt_q[j];
      end
    end
  end

  always_ff @(posedge clk50mhz or negedge nReset) begin
    if (!nReset) begin
      prev_q <= 6'b000000;
      filt_q <= 6'b000000;
      for (int j = 0; j < 6; j++) begin
        run_q[j] <= '0;
      end
    end else begin
      prev_q <= raw_s;
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign en_s = filt_q[2:0];
  assign hi_s = filt_q[5:3];
`else
  assign en_s = bus.phEn;
  assign hi_s = bus.phHi;
`endif

  // Stop request wins over a simultaneous clear.
  always_comb begin
    if (bus.m3forceStop) begin
      stopped_d = 1'b1;
    end else if (bus.stopClr) begin
      stopped_d = 1'b0;
    end else begin
      stopped_d = stopped_q;
    end
  end

  assign go_s = en_s & {3{~stopped_q & CFG_OK}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hp_d    = 3'b000;
    ln_d    = 3'b111;
    busy_d  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      case (state_q[i])
        ST_OFF: begin
          if (go_s[i]) begin
            state_d[i] = ST_DEAD;
            cnt_d[i]   = DT_LOAD;
          end else begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = '0;
          end
        end
        ST_DEAD: begin
          if (!go_s[i]) begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = hi_s[i] ? ST_HI : ST_LO;
          end else begin
            cnt_d[i]   = cnt_q[i] - CNT_W'(1);
          end
        end
        ST_HI, ST_LO: begin
          if (!go_s[i]) begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = '0;
          end else if (hi_s[i] != (state_q[i] == ST_HI)) begin
            state_d[i] = ST_DEAD;
            cnt_d[i]   = DT_LOAD;
          end else begin
            state_d[i] = state_q[i];
          end
        end
        default: begin
          state_d[i] = ST_OFF;
          cnt_d[i]   = '0;
        end
      endcase
      // Gate levels come from the next state so pins and state change on the same edge.
      hp_d[i]   = (state_d[i] == ST_HI);
      ln_d[i]   = (state_d[i] != ST_LO);
      busy_d[i] = (state_d[i] == ST_DEAD);
    end
  end

  always_ff @(posedge clk50mhz or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      hp_q      <= 3'b000;
      ln_q      <= 3'b111;
      busy_q    <= 3'b000;
      stopped_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hp_q      <= hp_d;
      ln_q      <= ln_d;
      busy_q    <= busy_d;
      stopped_q <= stopped_d;
    end
  end

  assign bus.aHP     = hp_q[0];
  assign bus.bHP     = hp_q[1];
  assign bus.cHP     = hp_q[2];
  assign bus.aLN     = ln_q[0];
  assign bus.bLN     = ln_q[1];
  assign bus.cLN     = ln_q[2];
  assign bus.dtBusy  = busy_q;
  assign bus.stopped = stopped_q;

endmodule

// File: doc/m3_deadtime_gate.md
Name: m3_deadtime_gate

Overview:
- Output stage of the 3-phase motor controller. It sits directly between the commutation/PWM logic and the six gate pins aHP/aLN, bHP/bLN, cHP/cLN.
- Converts per-phase "high side / low side / float" commands into gate drives with guaranteed dead time. It also enforces a latched emergency stop from m3forceStop.
- All gate outputs are registered.
- Gate polarity is fixed: xHP is active-high (1 = high-side on); xLN is active-low (0 = low-side on).
- Phase safe state: xHP=0, xLN=1.

Parameters:
- DEAD_CYC, 50, dead time in clk50mhz cycles (1 us). Legal range 1..1023.
- CNT_W, 10, width of each phase's dead-time counter.
- GLITCH_CYC, 4, command-stability requirement in cycles. Used only with M3_DT_GLITCH_FILTER_EN.

Ports:
- clk50mhz  in  1  system clock, 50 MHz
- nReset  in  1  asynchronous active-low reset
- phEn  in  3  per-phase drive enable, bit0=a, bit1=b, bit2=c; 0 = phase floats
- phHi  in  3  per-phase side select; 1 = high side, 0 = low side
- m3forceStop  in  1  emergency stop request, level
- stopClr  in  1  one-cycle pulse that clears the latched stop
- aHP, bHP, cHP  out  1 each  high-side gate, active-high
- aLN, bLN, cLN  out  1 each  low-side gate, active-low
- stopped  out  1  stop latch state
- dtBusy  out  3  per-phase flag: phase is in DEAD state

Behaviour:
- Reset: asynchronous, active-low on nReset.
  - While reset is asserted: all xHP=0, all xLN=1, stopped=1, dtBusy=0, all phase FSMs in OFF, counters=0.
  - Release is synchronous to clk50mhz.
- Per-phase FSM states: OFF, DEAD, HI, LO. Outputs are decoded from registered state, so there is no combinational path from inputs to gate pins.
  - OFF: HP=0, LN=1.
  - DEAD: HP=0, LN=1, dtBusy=1.
  - HI: HP=1, LN=1.
  - LO: HP=0, LN=0.
- Transitions, evaluated each rising edge:
  - Any state with phEn=0 or stopped=1 -> OFF at the next edge, with no dead time (turning off is always safe).
  - OFF with phEn=1 and stopped=0 -> DEAD; counter loads DEAD_CYC-1.
  - HI with phHi=0 -> DEAD; counter loads DEAD_CYC-1.
  - LO with phHi=1 -> DEAD; counter loads DEAD_CYC-1.
  - DEAD with counter>0 -> counter decrements.
  - DEAD with counter=0 -> HI if phHi=1, else LO.
- Dead-time timing:
  - If a command change is sampled at edge k, both gates are off from edge k.
  - The new side turns on at edge k+DEAD_CYC, giving exactly DEAD_CYC cycles of both-off.
  - The side actually driven is phHi as sampled on the exit edge.
  - If phHi toggles back during DEAD, the full dead time is still served. The counter is never reloaded or shortened while in DEAD.
- Stop latch:
  - stopped sets on the edge after m3forceStop=1 is sampled.
  - stopped clears on an edge where stopClr=1 and m3forceStop=0.
  - If stopClr and m3forceStop are both 1 in the same cycle, stop wins and stopped stays 1.
  - After reset, stopped=1, so stopClr is required before any drive.
- Phases are independent; simultaneous transitions on all three phases are legal.
- Invariant, checked by the bench every cycle: never xHP=1 and xLN=0 on the same phase.
- Reset asserted mid-DEAD or mid-HI forces the safe state immediately (asynchronous).

Optional Feature:
- Macro: M3_DT_GLITCH_FILTER_EN.
- When defined:
  - phEn and phHi per phase pass through a stability filter. A new value is accepted only after it has been sampled unchanged for GLITCH_CYC consecutive edges; the FSM then uses the filtered values.
  - Added latency: GLITCH_CYC cycles on every command change, including disable.
  - m3forceStop is not filtered.
- When undefined: raw phEn/phHi drive the FSMs directly and no filter logic is synthesised.

Test Plan:
All scenarios use DEAD_CYC=4 and the filter macro undefined unless stated.
- Reset then idle: nReset low 3 cycles -> all HP=0, LN=1, stopped=1. Set phEn=3'b111 with no stopClr -> outputs stay safe for 100 cycles.
- Enable from OFF: pulse stopClr, then phEn[0]=1, phHi[0]=1 sampled at edge k -> dtBusy[0]=1 for edges k..k+3; aHP=1 at edge k+4; aLN stays 1 throughout.
- HI->LO switch: phase a in HI, phHi[0]=0 at edge k -> aHP=0 at k; aLN=0 at k+4, not earlier.
- Toggle during DEAD: phHi[0] goes 1->0->1 within 2 cycles -> exactly 4 dead cycles from the first change, then aHP=1. No reload and no glitch on the gates.
- Force stop: all phases driving, m3forceStop=1 at edge k -> all gates safe at edge k+1. stopClr while m3forceStop=1 -> stopped stays 1. After m3forceStop=0 and stopClr -> stopped=0 and the phases re-enter via DEAD.
- Filter (M3_DT_GLITCH_FILTER_EN, GLITCH_CYC=4): phHi[0] 3-cycle pulse -> ignored, no DEAD entry. 4-cycle stable change -> DEAD starts 4 cycles later than the unfiltered case.
